// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - four-requester packet-locked write arbiter in front of a FIFO write port
// Optional feature macro: FIFO_WR_ARB_PRIO_EN (requester 0 wins every arbitration in which it requests)
module fifo_wr_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            req_last,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  wfull,
  output logic [3:0]            gnt,
  output logic [3:0]            ack,
  output logic                  winc,
  output logic [DATA_W-1:0]     wdata,
  output logic                  pkt_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state_q,      state_d;
  logic [3:0]       gnt_q,        gnt_d;
  logic [1:0]       last_owner_q, last_owner_d;
  logic [CNT_W-1:0] beat_cnt_q,   beat_cnt_d;
  logic             pkt_err_q,    pkt_err_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic             owner_last;
  logic             at_max;
  logic             release_pkt;
  logic             forced;

  // Beat handshake: only the granted requester can be acked, and never while the FIFO is full
  assign ack  = gnt_q & req & {4{~wfull}};
  assign winc = |ack;
  assign gnt  = gnt_q;
  assign pkt_err = pkt_err_q;

  assign owner_last  = |(gnt_q & req_last);
  assign at_max      = (beat_cnt_q == CNT_MAX);
  assign release_pkt = winc & (owner_last | at_max);
  assign forced      = winc & ~owner_last & at_max;

  // Data mux from the one-hot grant; zero when nobody owns the port
  always_comb begin
    wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_q[i]) begin
        wdata = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search starting just above the previous owner; previous owner is checked last
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_owner_q + 2'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef FIFO_WR_ARB_PRIO_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_idx   = 2'd0;
    end
`else
`endif
  end

  // Grant FSM: lock on grant, release on accepted last beat or on beat-count overflow
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_err_d    = pkt_err_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d      = ST_LOCK;
          gnt_d        = 4'b0001 << win_idx;
          last_owner_d = win_idx;
          beat_cnt_d   = '0;
        end
      end
      ST_LOCK: begin
        if (release_pkt) begin
          beat_cnt_d = '0;
          if (forced) begin
            pkt_err_d = 1'b1;
          end
          if (win_found) begin
            gnt_d        = 4'b0001 << win_idx;
            last_owner_d = win_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (winc) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State registers; reset leaves last_owner at 3 so requester 0 is searched first
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 4'b0000;
      last_owner_q <= 2'd3;
      beat_cnt_q   <= '0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb against a packet-level reference model
module tb_fifo_wr_arb;

  localparam int DW   = 8;
  localparam int MAXB = 16;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [3:0]      req;
  logic [3:0]      req_last;
  logic [4*DW-1:0] req_data;
  logic            wfull;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic            pkt_err;

  fifo_wr_arb #(.DATA_W(DW), .MAX_BEATS(MAXB)) dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .req      (req),
    .req_last (req_last),
    .req_data (req_data),
    .wfull    (wfull),
    .gnt      (gnt),
    .ack      (ack),
    .winc     (winc),
    .wdata    (wdata),
    .pkt_err  (pkt_err)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [3:0]    gnt;
    logic [3:0]    ack;
    logic          winc;
    logic [DW-1:0] wdata;
    logic          err;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: owner -1 means nobody holds the port
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic int pick(input logic [3:0] r);
`ifdef FIFO_WR_ARB_PRIO_EN
    if (r[0]) return 0;
`else
`endif
    for (int k = 1; k <= 4; k++) begin
      if (r[(m_last + k) % 4]) return (m_last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_cnt   = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step();
    exp_t e;
    bit   acc;
    int   w;
    e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    acc     = (m_owner >= 0) && req[m_owner] && !wfull;
    e.ack   = acc ? e.gnt : 4'b0000;
    e.winc  = acc;
    e.wdata = (m_owner >= 0) ? req_data[m_owner*DW +: DW] : '0;
    e.err   = m_err;
    exp_q.push_back(e);
    if (m_owner < 0) begin
      w = pick(req);
      if (w >= 0) begin
        m_owner = w;
        m_last  = w;
        m_cnt   = 0;
      end
    end else if (acc) begin
      m_cnt++;
      if (req_last[m_owner] || m_cnt == MAXB) begin
        if (!req_last[m_owner]) m_err = 1'b1;
        m_cnt   = 0;
        w       = pick(req);
        m_owner = w;
        if (w >= 0) m_last = w;
      end
    end
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic wf);
    @(negedge wclk);
    req      = r;
    req_last = l;
    wfull    = wf;
    for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = DW'($urandom);
    #1;
    model_step();
  endtask

  task automatic reset_now();
    @(negedge wclk);
    req    = 4'b0000;
    wrst_n = 1'b0;
    #1;
    check("rst_gnt",   32'(gnt),   32'h0);
    check("rst_winc",  32'(winc),  32'h0);
    check("rst_ack",   32'(ack),   32'h0);
    check("rst_wdata", 32'(wdata), 32'h0);
    check("rst_err",   32'(pkt_err), 32'h0);
    model_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  // monitor: compares the DUT against the oldest expected cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("gnt",     32'(gnt),     32'(e.gnt));
        check("ack",     32'(ack),     32'(e.ack));
        check("winc",    32'(winc),    32'(e.winc));
        if (e.winc) check("wdata", 32'(wdata), 32'(e.wdata));
        else        check("wdata_idle_or_stall", 32'(wdata), 32'(e.wdata));
        check("pkt_err", 32'(pkt_err), 32'(e.err));
      end
    end
  end

  initial begin
    wrst_n   = 1'b0;
    req      = 4'b0000;
    req_last = 4'b0000;
    req_data = '0;
    wfull    = 1'b0;
    model_reset();
    repeat (3) @(negedge wclk);
    wrst_n = 1'b1;
    #1;
    check("init_gnt", 32'(gnt),     32'h0);
    check("init_err", 32'(pkt_err), 32'h0);

    // two requesters, every beat last: round-robin alternation
    repeat (6) cycle(4'b0110, 4'b1111, 1'b0);
    // requester 2 three-beat packet while requester 1 waits
    cycle(4'b0000, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0110, 4'b0000, 1'b0);
    cycle(4'b0110, 4'b0000, 1'b0);
    cycle(4'b0110, 4'b0100, 1'b0);
    cycle(4'b0010, 4'b0010, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    // full stall mid-packet, owner dropping req mid-packet
    cycle(4'b0100, 4'b0000, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0);
    repeat (5) cycle(4'b0110, 4'b0000, 1'b1);
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0110, 4'b0100, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    // requester 3 overruns the beat limit
    repeat (22) cycle(4'b1000, 4'b0000, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b0);
    // two requesters 0 and 3, all last: priority or alternation
    repeat (8) cycle(4'b1001, 4'b1111, 1'b0);
    // randomized traffic
    repeat (1500) cycle(4'($urandom), 4'($urandom & $urandom), ($urandom_range(0, 4) == 0));
    // reset mid-packet, then requester 0 first
    repeat (3) cycle(4'b1110, 4'b0000, 1'b0);
    reset_now();
    repeat (4) cycle(4'b1111, 4'b1111, 1'b0);
    repeat (1500) cycle(4'($urandom), 4'($urandom & $urandom & $urandom), ($urandom_range(0, 3) == 0));
    repeat (3) @(negedge wclk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
